// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser: optional screen clear, then eight-way symmetric plotting with backpressure.
// Define CIRCLE_CLIP_EN to skip off-screen DRAW points instead of wrapping them.
module circle_engine #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 7,
    parameter int CW       = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_clear,
    input  logic [XW-1:0] cmd_cx,
    input  logic [YW-1:0] cmd_cy,
    input  logic [RW-1:0] cmd_radius,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          pix_plot,
    input  logic          pix_ready,
    output logic          busy,
    output logic          done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic signed [RW+1:0] ONE_O = 1;
    localparam logic signed [RW+2:0] ONE_C = 1;
    localparam logic [XW-1:0] CLR_X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] CLR_Y_LAST = YW'(SCREEN_H - 1);

    logic [2:0]             state_q, state_d;
    logic [XW-1:0]          cx_q, cx_d;
    logic [YW-1:0]          cy_q, cy_d;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          col_q, col_d;
    logic [XW-1:0]          clr_x_q, clr_x_d;
    logic [YW-1:0]          clr_y_q, clr_y_d;
    logic signed [RW+1:0]   ox_q, ox_d, oy_q, oy_d;
    logic signed [RW+2:0]   crit_q, crit_d;
    logic [2:0]             k_q, k_d;

    logic signed [XW+1:0]   px, dx, ox_x, oy_x;
    logic signed [YW+1:0]   py, dy, ox_y, oy_y;
    logic                   in_range;
    logic signed [RW+1:0]   ox_n, oy_n;
    logic signed [RW+2:0]   ox_c, oy_c;
    logic                   crit_le0;

    // Signed offsets widened to the coordinate width so cx-oy can go negative.
    assign ox_x = (XW+2)'(ox_q);
    assign oy_x = (XW+2)'(oy_q);
    assign ox_y = (YW+2)'(ox_q);
    assign oy_y = (YW+2)'(oy_q);

    always_comb begin
        dx = ox_x;
        dy = oy_y;
        case (k_q)
            3'd0: begin dx =  ox_x; dy =  oy_y; end
            3'd1: begin dx =  oy_x; dy =  ox_y; end
            3'd2: begin dx = -ox_x; dy =  oy_y; end
            3'd3: begin dx = -oy_x; dy =  ox_y; end
            3'd4: begin dx = -ox_x; dy = -oy_y; end
            3'd5: begin dx = -oy_x; dy = -ox_y; end
            3'd6: begin dx =  ox_x; dy = -oy_y; end
            default: begin dx = oy_x; dy = -ox_y; end
        endcase
    end

    assign px = $signed({2'b00, cx_q}) + dx;
    assign py = $signed({2'b00, cy_q}) + dy;

`ifdef CIRCLE_CLIP_EN
    localparam logic signed [XW+1:0] SW_S = (XW+2)'(SCREEN_W);
    localparam logic signed [YW+1:0] SH_S = (YW+2)'(SCREEN_H);
    assign in_range = !(px[XW+1] || py[YW+1] || (px >= SW_S) || (py >= SH_S));
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        pix_plot   = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        pix_colour = '0;
        case (state_q)
            S_CLEAR: begin
                pix_plot = 1'b1;
                pix_x    = clr_x_q;
                pix_y    = clr_y_q;
            end
            S_DRAW: begin
                pix_plot   = in_range;
                pix_x      = px[XW-1:0];
                pix_y      = py[YW-1:0];
                pix_colour = col_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    // Midpoint decision update; oy may dip to -1 for radius 0, hence signed offsets.
    assign crit_le0 = crit_q[RW+2] || (crit_q == '0);
    assign ox_n     = ox_q + ONE_O;
    assign oy_n     = crit_le0 ? oy_q : (oy_q - ONE_O);
    assign ox_c     = (RW+3)'(ox_n);
    assign oy_c     = (RW+3)'(oy_n);

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        col_d   = col_q;
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                cx_d    = cmd_cx;
                cy_d    = cmd_cy;
                r_d     = cmd_radius;
                col_d   = cmd_colour;
                clr_x_d = '0;
                clr_y_d = '0;
                state_d = cmd_clear ? S_CLEAR : S_INIT;
            end
            S_CLEAR: if (pix_ready) begin
                if (clr_x_q == CLR_X_LAST) begin
                    clr_x_d = '0;
                    if (clr_y_q == CLR_Y_LAST) state_d = S_INIT;
                    else                       clr_y_d = clr_y_q + 1'b1;
                end else begin
                    clr_x_d = clr_x_q + 1'b1;
                end
            end
            S_INIT: begin
                ox_d    = '0;
                oy_d    = $signed({2'b00, r_q});
                crit_d  = ONE_C - $signed({3'b000, r_q});
                k_d     = 3'd0;
                state_d = S_DRAW;
            end
            S_DRAW: if (!pix_plot || pix_ready) begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                ox_d    = ox_n;
                oy_d    = oy_n;
                crit_d  = crit_le0 ? (crit_q + (ox_c <<< 1) + ONE_C)
                                   : (crit_q + ((ox_c - oy_c) <<< 1) + ONE_C);
                k_d     = 3'd0;
                state_d = (ox_n <= oy_n) ? S_DRAW : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            col_q   <= '0;
            clr_x_q <= '0;
            clr_y_q <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            col_q   <= col_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
            k_q     <= k_d;
        end
    end
endmodule

// File: tb/tb_circle_engine.sv
// Scoreboard bench for circle_engine: a plain-integer midpoint model fills an expected-pixel
// queue per command, and a negedge monitor pops and compares every accepted pixel.
module tb_circle_engine;
    localparam int XW = 8, YW = 7, RW = 7, CW = 3;
    localparam int SW = 4, SH = 2;

    logic          clock = 1'b0;
    logic          resetb = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_clear = 1'b0;
    logic [XW-1:0] cmd_cx = '0;
    logic [YW-1:0] cmd_cy = '0;
    logic [RW-1:0] cmd_radius = '0;
    logic [CW-1:0] cmd_colour = '0;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;
    logic          pix_plot;
    logic          pix_ready = 1'b1;
    logic          busy;
    logic          done;

    circle_engine #(.XW(XW), .YW(YW), .RW(RW), .CW(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock(clock), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
        .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_radius(cmd_radius), .cmd_colour(cmd_colour),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_plot(pix_plot),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic add_pix(input int x, input int y, input int c);
        pix_t p;
`ifdef CIRCLE_CLIP_EN
        if (x < 0 || x >= SW || y < 0 || y >= SH) return;
`endif
        p.x = x & ((1 << XW) - 1);
        p.y = y & ((1 << YW) - 1);
        p.c = c;
        exp_q.push_back(p);
    endtask

    // Reference: screen clear followed by the midpoint circle in plain integer arithmetic.
    task automatic model_cmd(input int clr, input int cx, input int cy, input int r, input int c);
        int ox, oy, crit;
        if (clr != 0)
            for (int y = 0; y < SH; y++)
                for (int x = 0; x < SW; x++) add_pix(x, y, 0);
        ox = 0; oy = r; crit = 1 - r;
        do begin
            add_pix(cx + ox, cy + oy, c);
            add_pix(cx + oy, cy + ox, c);
            add_pix(cx - ox, cy + oy, c);
            add_pix(cx - oy, cy + ox, c);
            add_pix(cx - ox, cy - oy, c);
            add_pix(cx - oy, cy - ox, c);
            add_pix(cx + ox, cy - oy, c);
            add_pix(cx + oy, cy - ox, c);
            ox = ox + 1;
            if (crit <= 0) crit = crit + 2 * ox + 1;
            else begin oy = oy - 1; crit = crit + 2 * (ox - oy) + 1; end
        end while (ox <= oy);
    endtask

    // pix_ready pattern: always, one cycle in three, or random.
    initial begin
        int cyc3 = 0;
        forever begin
            @(posedge clock); #2;
            cyc3 = (cyc3 + 1) % 3;
            case (rdy_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = (cyc3 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares accepted pixels, hold stability under stall, and done behaviour.
    initial begin
        logic held_v = 1'b0, prev_done = 1'b0;
        int hx = 0, hy = 0, hc = 0;
        pix_t e;
        forever begin
            @(negedge clock);
            if (!resetb) begin
                held_v = 1'b0; prev_done = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_plot", int'(pix_plot), 1);
                    check("stall_x", int'(pix_x), hx);
                    check("stall_y", int'(pix_y), hy);
                    check("stall_col", int'(pix_colour), hc);
                end
                if (pix_plot && pix_ready) begin
                    if (exp_q.size() == 0) check("extra_pixel", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("pix_x", int'(pix_x), e.x);
                        check("pix_y", int'(pix_y), e.y);
                        check("pix_col", int'(pix_colour), e.c);
                    end
                end
                held_v = pix_plot && !pix_ready;
                hx = int'(pix_x); hy = int'(pix_y); hc = int'(pix_colour);
                if (done) begin
                    done_cnt++;
                    check("pending_at_done", exp_q.size(), 0);
                    check("done_single", int'(prev_done), 0);
                end
                prev_done = done;
            end
        end
    end

    task automatic issue(input int clr, input int cx, input int cy, input int r, input int c);
        model_cmd(clr, cx, cy, r, c);
        @(posedge clock); #1;
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_clear = 1'(clr);
        cmd_cx = XW'(cx); cmd_cy = YW'(cy); cmd_radius = RW'(r); cmd_colour = CW'(c);
        @(posedge clock); #1;
        // Offer a junk command while busy; it must be ignored.
        cmd_cx = ~cmd_cx; cmd_radius = 7'd3; cmd_colour = ~cmd_colour; cmd_clear = 1'b1;
        check("ready_while_busy", int'(cmd_ready), 0);
        check("busy_after_accept", int'(busy), 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int cyc = 0;
        while (done_cnt == start && cyc < 20000) begin
            @(negedge clock); #1;
            cyc++;
        end
        if (done_cnt == start) check("done_timeout", 0, 1);
        else begin
            @(negedge clock); #1;
            check("ready_after_done", int'(cmd_ready), 1);
            check("idle_after_done", int'(busy), 0);
        end
    endtask

    task automatic run(input int clr, input int cx, input int cy, input int r, input int c);
        issue(clr, cx, cy, r, c);
        wait_done();
    endtask

    initial begin
        resetb = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_plot", int'(pix_plot), 0);
        check("rst_x", int'(pix_x), 0);
        check("rst_y", int'(pix_y), 0);
        check("rst_col", int'(pix_colour), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clock); resetb = 1'b1;
        #1 check("rst_ready", int'(cmd_ready), 1);

        rdy_mode = 0; run(0, 80, 60, 0, 5);
        rdy_mode = 0; run(0, 80, 60, 1, 3);
        rdy_mode = 0; run(1, 1, 1, 0, 6);
        rdy_mode = 1; run(0, 80, 60, 1, 3);
        rdy_mode = 0; run(0, 0, 0, 1, 7);
        rdy_mode = 2; run(1, 255, 127, 5, 2);

        for (int i = 0; i < 20; i++) begin
            rdy_mode = int'($urandom_range(0, 2));
            run(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 30)), int'($urandom_range(0, 7)));
        end

        // Reset in the middle of a large circle, then a fresh command.
        rdy_mode = 0;
        issue(0, 80, 60, 20, 4);
        repeat (15) @(posedge clock);
        #3 resetb = 1'b0;
        #1;
        check("midrst_plot", int'(pix_plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_x", int'(pix_x), 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock); resetb = 1'b1;
        run(0, 80, 60, 0, 5);
        run(0, 2, 0, 2, 1);

        repeat (3) @(posedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/circle_engine.md
Name: circle_engine

Overview:
Parametrised midpoint-circle rasteriser with an integrated datapath. Accepts one circle command per valid/ready handshake, optionally clears the screen first, then streams pixels to the framebuffer writer over a plot/ready handshake with backpressure. It replaces the fixed-size, fixed-sequence circle controller and its external datapath. The software-free top level queues commands into it.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
RW, 7, radius width
CW, 3, colour width
SCREEN_W, 160, visible columns (≤ 2^XW)
SCREEN_H, 120, visible rows (≤ 2^YW)

Ports:
clock  in  1  system clock
resetb  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_clear  in  1  clear screen before drawing
cmd_cx  in  XW  centre x
cmd_cy  in  YW  centre y
cmd_radius  in  RW  radius, unsigned
cmd_colour  in  CW  circle colour
pix_x  out  XW  pixel x
pix_y  out  YW  pixel y
pix_colour  out  CW  pixel colour
pix_plot  out  1  pixel valid
pix_ready  in  1  framebuffer accepts pixel
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Interface: reset resetb, asynchronous, active-low; clock clock.
- Reset (any time, including mid-command): state IDLE, all internal registers cleared. pix_plot=0, pix_x=0, pix_y=0, pix_colour=0, busy=0, done=0, cmd_ready=1 once resetb is high. A partially drawn circle is abandoned.
- Handshake: a command is accepted on cmd_valid&&cmd_ready. All cmd_* fields are registered on acceptance. The next state is CLEAR if cmd_clear=1, otherwise INIT.
- Pixel handshake: pix_x, pix_y, pix_colour and pix_plot are held stable while pix_plot&&!pix_ready. A pixel advances only on pix_plot&&pix_ready.
- States: IDLE, CLEAR, INIT, DRAW, UPDATE, DONE.
- CLEAR: raster scan with x inner and y outer, from (0,0) to (SCREEN_W-1,SCREEN_H-1), colour 0. After the last pixel is accepted, go to INIT.
- INIT, 1 cycle:
  - ox=0, oy=radius, crit=1-radius.
  - Octant counter k=0.
  - pix_plot=0.
- DRAW: one cycle minimum per point, k=0..7. Point order, with signed arithmetic at XW+2 / YW+2 bits:
  - (cx+ox, cy+oy), (cx+oy, cy+ox), (cx-ox, cy+oy), (cx-oy, cy+ox)
  - (cx-ox, cy-oy), (cx-oy, cy-ox), (cx+ox, cy-oy), (cx+oy, cy-ox)
  - After k=7 completes, go to UPDATE.
- UPDATE, 1 cycle, pix_plot=0:
  - ox'=ox+1.
  - If crit≤0: crit'=crit+2*ox'+1.
  - Else: oy'=oy-1 and crit'=crit+2*(ox'-oy')+1.
  - crit is a signed register of RW+3 bits.
  - Then, if ox'≤oy', go to DRAW with k=0; else go to DONE.
- DONE, 1 cycle: done=1, busy=1, then IDLE.
- radius=0: one iteration of 8 plots, all at (cx,cy). Duplicate points are always emitted, never suppressed.
- cmd_valid while busy is ignored; cmd_ready=0.
- Wrap-around (macro absent): coordinates are truncated modulo 2^XW / 2^YW.

Optional Feature:
CIRCLE_CLIP_EN.
- Defined: any DRAW point with x<0, x≥SCREEN_W, y<0 or y≥SCREEN_H takes one cycle with pix_plot=0 and k advances. CLEAR is unaffected.
- Undefined: all 8 points are plotted with truncated coordinates, with no range check.

Test Plan:
1. Reset then cx=80, cy=60, r=0, colour=5, clear=0, pix_ready=1 → exactly 8 plots at (80,60) colour 5, then a done pulse, then cmd_ready=1.
2. cx=80, cy=60, r=1, pix_ready=1 → 16 plots in this order, then done:
   - (80,61) (81,60) (80,61) (79,60) (80,59) (79,60) (80,59) (81,60)
   - (81,61) (81,61) (79,61) (79,61) (79,59) (79,59) (81,59) (81,59)
3. SCREEN_W=4, SCREEN_H=2, clear=1, r=0 at (1,1) → 8 colour-0 plots in raster order (0,0)…(3,1), then 8 plots at (1,1).
4. Test 2 with pix_ready toggling 1-of-3 cycles → identical pixel sequence. Outputs are held stable while stalled. done is delayed accordingly.
5. cx=0, cy=0, r=1:
   - With CIRCLE_CLIP_EN: 6 plots, (0,1) (1,0) (0,1) (1,0) (1,1) (1,1).
   - Without it: 16 plots, with -1 appearing as x=255 / y=127.
6. resetb pulsed low mid-DRAW of r=20 → pix_plot=0 and busy=0 immediately. A new command with r=0 then completes normally with 8 plots.
